// File: rtl/trigger_ack_ctrl_if.sv
// Trigger handshake and readout-window signals shared between the TLU slave core,
// the readout logic and trigger_ack_ctrl.
interface trigger_ack_ctrl_if;
  logic trigger_accepted_flag;
  logic trigger_acknowledge;
  logic readout_busy;
  logic readout_start;
  logic window;

  modport master (
    output trigger_accepted_flag,
    output readout_busy,
    input  trigger_acknowledge,
    input  readout_start,
    input  window
  );

  modport slave (
    input  trigger_accepted_flag,
    input  readout_busy,
    output trigger_acknowledge,
    output readout_start,
    output window
  );
endinterface

// File: rtl/trigger_ack_ctrl.sv
// Trigger-domain sequencer: accepted flag -> delayed readout window -> wait for readout
// idle -> one-cycle acknowledge, plus trigger and error statistics.
//
// state    | meaning
// S_IDLE   | ready for the next accepted trigger
// S_DELAY  | counting down the latched delay
// S_WINDOW | readout window open for the latched length
// S_WAIT   | holding the acknowledge until readout is idle
// S_ACK    | acknowledge pulse to the TLU slave core
module trigger_ack_ctrl #(
  parameter int DELAY_WIDTH  = 8,
  parameter int LENGTH_WIDTH = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    trigger_clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [DELAY_WIDTH-1:0]  delay,
  input  logic [LENGTH_WIDTH-1:0] length,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    trigger_cnt,
  output logic [7:0]              error_cnt,
  trigger_ack_ctrl_if.slave       tlu
);

  localparam int TW = (DELAY_WIDTH > LENGTH_WIDTH) ? DELAY_WIDTH : LENGTH_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_WINDOW, S_WAIT, S_ACK} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0]    trig_cnt_q, trig_cnt_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic                    busy_q, busy_d;
  logic                    window_q, window_d;
  logic                    start_q, start_d;
  logic                    ack_q, ack_d;
  logic                    accept, stray;

  // A zero length still opens a single-cycle window.
  function automatic logic [TW-1:0] len_minus1(input logic [LENGTH_WIDTH-1:0] l);
    return (l == '0) ? '0 : (TW'(l) - TW'(1));
  endfunction

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      len_q      <= '0;
      trig_cnt_q <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
      window_q   <= 1'b0;
      start_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      len_q      <= len_d;
      trig_cnt_q <= trig_cnt_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
      window_q   <= window_d;
      start_q    <= start_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    len_d   = len_q;
    accept  = tlu.trigger_accepted_flag && enable && (state_q == S_IDLE);
    stray   = tlu.trigger_accepted_flag && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d = length;
          if (delay != '0) begin
            state_d = S_DELAY;
            timer_d = TW'(delay) - TW'(1);
          end else begin
            state_d = S_WINDOW;
            timer_d = len_minus1(length);
          end
        end
      end
      S_DELAY: begin
        if (timer_q == '0) begin
          state_d = S_WINDOW;
          timer_d = len_minus1(len_q);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_WINDOW: begin
        if (timer_q == '0) state_d = S_WAIT;
        else               timer_d = timer_q - TW'(1);
      end
      S_WAIT:  if (!tlu.readout_busy) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d   = (state_d != S_IDLE);
    window_d = (state_d == S_WINDOW);
    start_d  = (state_d == S_WINDOW) && (state_q != S_WINDOW);
    ack_d    = (state_d == S_ACK);

    if (clear)       trig_cnt_d = '0;
    else if (accept) trig_cnt_d = trig_cnt_q + CNT_WIDTH'(1);
    else             trig_cnt_d = trig_cnt_q;

    if (clear)                              err_cnt_d = '0;
    else if (stray && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
    else                                    err_cnt_d = err_cnt_q;
  end

  assign busy                    = busy_q;
  assign trigger_cnt             = trig_cnt_q;
  assign error_cnt               = err_cnt_q;
  assign tlu.window              = window_q;
  assign tlu.readout_start       = start_q;
  assign tlu.trigger_acknowledge = ack_q;

endmodule

// File: tb/tb_trigger_ack_ctrl.sv
// Bench for trigger_ack_ctrl: directed test-plan sequences plus random traffic, all
// checked cycle by cycle against a timestamp-based reference model.
module tb_trigger_ack_ctrl;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int CW = 8;

  logic          trigger_clk = 1'b0;
  logic          reset_n     = 1'b0;
  logic          enable      = 1'b0;
  logic          clear       = 1'b0;
  logic [DW-1:0] delay       = '0;
  logic [LW-1:0] length      = '0;
  logic          busy;
  logic [CW-1:0] trigger_cnt;
  logic [7:0]    error_cnt;

  trigger_ack_ctrl_if tlu ();

  trigger_ack_ctrl #(.DELAY_WIDTH(DW), .LENGTH_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .trigger_clk (trigger_clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .delay       (delay),
    .length      (length),
    .busy        (busy),
    .trigger_cnt (trigger_cnt),
    .error_cnt   (error_cnt),
    .tlu         (tlu)
  );

  always #5 trigger_clk = ~trigger_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one trigger described by its timestamps.
  int cyc = 0;
  bit m_act = 0;
  int m_t, m_d, m_l;
  int m_ack = -1;
  int m_trig = 0;
  int m_err = 0;

  int last_ack = -1;
  int last_start = -1;
  int n_start = 0;
  int t;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit e_win, e_st, e_ack;
    e_win = m_act && (cyc >= m_t + 1 + m_d) && (cyc <= m_t + m_d + m_l);
    e_st  = m_act && (cyc == m_t + 1 + m_d);
    e_ack = m_act && (cyc == m_ack);
    chk("busy",   busy,                    m_act);
    chk("window", tlu.window,              e_win);
    chk("start",  tlu.readout_start,       e_st);
    chk("ack",    tlu.trigger_acknowledge, e_ack);
    chk("trig",   trigger_cnt,             m_trig);
    chk("err",    error_cnt,               m_err);
  endtask

  task automatic model_edge(input bit flag, input bit rb);
    if (m_act) begin
      if (flag && m_err < 255) m_err++;
      if (cyc == m_ack) m_act = 0;
      else if (m_ack < 0 && cyc >= m_t + 1 + m_d + m_l && !rb) m_ack = cyc + 1;
    end else if (flag && enable) begin
      m_act  = 1;
      m_t    = cyc;
      m_d    = int'(delay);
      m_l    = (length == '0) ? 1 : int'(length);
      m_ack  = -1;
      m_trig = (m_trig + 1) % (1 << CW);
    end
    if (clear) begin
      m_trig = 0;
      m_err  = 0;
    end
  endtask

  task automatic step(input bit flag, input bit rb);
    check_outputs();
    if (tlu.trigger_acknowledge) last_ack = cyc;
    if (tlu.readout_start) begin
      last_start = cyc;
      n_start++;
    end
    tlu.trigger_accepted_flag = flag;
    tlu.readout_busy          = rb;
    @(posedge trigger_clk);
    model_edge(flag, rb);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    tlu.trigger_accepted_flag = 1'b0;
    tlu.readout_busy          = 1'b0;
    reset_n = 1'b0;
    #1;
    m_act  = 0;
    m_ack  = -1;
    m_trig = 0;
    m_err  = 0;
    check_outputs();
    @(posedge trigger_clk);
    cyc++;
    #1;
    check_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    tlu.trigger_accepted_flag = 1'b0;
    tlu.readout_busy          = 1'b0;
    repeat (2) @(posedge trigger_clk);
    #1;
    check_outputs();
    reset_n = 1'b1;
    enable  = 1'b1;

    // basic sequence
    delay = 3; length = 4; t = cyc;
    step(1, 0);
    repeat (12) step(0, 0);
    chk("basic_start_lat", last_start - t, 4);
    chk("basic_ack_lat", last_ack - t, 9);
    chk("basic_trig", trigger_cnt, 1);

    // zero settings
    delay = 0; length = 0; t = cyc;
    step(1, 0);
    repeat (6) step(0, 0);
    chk("zero_start_lat", last_start - t, 1);
    chk("zero_ack_lat", last_ack - t, 3);

    // back-pressure: readout busy through t+9
    delay = 0; length = 2; t = cyc;
    step(1, 1);
    for (int i = 1; i <= 12; i++) step(0, (cyc - t) < 10);
    chk("bp_ack_lat", last_ack - t, 11);

    // stray flags during a sequence
    delay = 2; length = 3; n_start = 0; t = cyc;
    step(1, 0);
    step(1, 0);
    step(1, 0);
    repeat (10) step(0, 0);
    chk("stray_err", error_cnt, 2);
    chk("stray_starts", n_start, 1);

    // enable dropped mid-sequence
    t = cyc;
    step(1, 0);
    enable = 1'b0;
    repeat (10) step(0, 0);
    chk("endrop_ack_lat", last_ack - t, 7);

    // flag with enable low in idle
    n_start = 0;
    step(1, 0);
    repeat (4) step(0, 0);
    chk("dis_trig", trigger_cnt, 5);
    chk("dis_err", error_cnt, 2);
    chk("dis_starts", n_start, 0);

    // error counter saturation
    enable = 1'b1; delay = 0; length = 1;
    step(1, 1);
    repeat (260) step(1, 1);
    repeat (4) step(0, 0);
    chk("sat_err", error_cnt, 255);
    chk("sat_trig", trigger_cnt, 6);

    // trigger counter wrap
    repeat (250) begin
      step(1, 0);
      repeat (3) step(0, 0);
    end
    chk("wrap_trig", trigger_cnt, 0);

    // clear coincident with an accepted flag
    step(1, 0);
    repeat (3) step(0, 0);
    clear = 1'b1;
    step(1, 0);
    clear = 1'b0;
    chk("clr_trig", trigger_cnt, 0);
    chk("clr_err", error_cnt, 0);
    repeat (4) step(0, 0);

    // reset in the middle of a window
    delay = 0; length = 6;
    step(1, 0);
    step(0, 0);
    step(0, 0);
    do_reset();
    chk("rst_window", tlu.window, 0);
    chk("rst_busy", busy, 0);
    last_ack = -1;
    repeat (10) step(0, 0);
    chk("rst_noack", last_ack, -1);
    delay = 1; length = 2; t = cyc;
    step(1, 0);
    repeat (8) step(0, 0);
    chk("post_rst_ack_lat", last_ack - t, 5);
    chk("post_rst_trig", trigger_cnt, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 49) == 0);
      delay  = DW'($urandom_range(0, 4));
      length = LW'($urandom_range(0, 4));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    clear = 1'b0;
    repeat (20) step(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
